// File: rtl/por_seq_pkg.sv
// Shared state encoding and default timing for the power-on reset sequencer.
package por_seq_pkg;

  localparam int unsigned CoreDlyDef = 16;
  localparam int unsigned UserDlyDef = 8;
  localparam int unsigned LockTmoDef = 1024;
  localparam int unsigned CntWDef    = 11;

  typedef enum logic [2:0] {
    StOff,
    StPll,
    StCore,
    StUser,
    StRun
  } seq_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs; clears to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: waits for supply good, enables the PLL, then releases
// the core reset and finally the user reset after fixed delays.
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int unsigned CORE_DLY = CoreDlyDef,
  parameter int unsigned USER_DLY = UserDlyDef,
  parameter int unsigned LOCK_TMO = LockTmoDef,
  parameter int unsigned CNT_W    = CntWDef
) (
  input  logic clk,
  input  logic resetb,
  input  logic porb_l,
  input  logic pll_lock,
  input  logic soft_rst,
  output logic pll_ena,
  output logic core_resetb,
  output logic user_resetb,
  output logic seq_done,
  output logic lock_tmo
);

  localparam logic [CNT_W-1:0] CoreLast = CNT_W'(CORE_DLY - 1);
  localparam logic [CNT_W-1:0] UserLast = CNT_W'(USER_DLY - 1);
  localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_TMO - 1);

  logic porb_s, lock_s;
  logic lock_q;
  logic tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seq_state_e state_q, state_d;

  sync2 u_sync_porb (
    .clk    (clk),
    .resetb (resetb),
    .d      (porb_l),
    .q      (porb_s)
  );

  sync2 u_sync_lock (
    .clk    (clk),
    .resetb (resetb),
    .d      (pll_lock),
    .q      (lock_s)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = lock_tmo;
    if (!porb_s) begin
      state_d = StOff;
    end else begin
      case (state_q)
        StOff:  state_d = StPll;
        StPll: begin
          if (lock_s) begin
            state_d = StCore;
          end else if (cnt_q == LockLast) begin
            state_d = StCore;
            tmo_d   = 1'b1;
          end
        end
        StCore: if (cnt_q == CoreLast) state_d = StUser;
        StUser: if (cnt_q == UserLast) state_d = StRun;
        // A lost lock only restarts the core when lock was actually achieved.
        StRun:  if (soft_rst || (lock_q && !lock_s && !lock_tmo)) state_d = StCore;
        default: state_d = StOff;
      endcase
    end
    if (state_d == StOff) tmo_d = 1'b0;

    cnt_d = '0;
    if ((state_d == state_q) && (state_q inside {StPll, StCore, StUser})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they switch together with state_q.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      lock_tmo    <= 1'b0;
      pll_ena     <= 1'b0;
      core_resetb <= 1'b0;
      user_resetb <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_s;
      lock_tmo    <= tmo_d;
      pll_ena     <= (state_d != StOff);
      core_resetb <= (state_d inside {StUser, StRun});
      user_resetb <= (state_d == StRun);
      seq_done    <= (state_d == StRun);
    end
  end

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench for the power-on reset sequencer using default timing parameters.
module tb_por_reset_sequencer;

  logic clk;
  logic resetb;
  logic porb_l;
  logic pll_lock;
  logic soft_rst;
  logic pll_ena;
  logic core_resetb;
  logic user_resetb;
  logic seq_done;
  logic lock_tmo;
  logic [3:0] outs;

  int checks = 0;
  int errors = 0;

  por_reset_sequencer dut (
    .clk         (clk),
    .resetb      (resetb),
    .porb_l      (porb_l),
    .pll_lock    (pll_lock),
    .soft_rst    (soft_rst),
    .pll_ena     (pll_ena),
    .core_resetb (core_resetb),
    .user_resetb (user_resetb),
    .seq_done    (seq_done),
    .lock_tmo    (lock_tmo)
  );

  assign outs = {pll_ena, core_resetb, user_resetb, seq_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // exp_outs order: {pll_ena, core_resetb, user_resetb, seq_done}
  task automatic chk(input string tag, input logic [3:0] exp_outs, input logic exp_tmo);
    checks++;
    assert (outs === exp_outs) else begin
      errors++;
      $error("FAIL %s outputs: observed %b expected %b", tag, outs, exp_outs);
    end
    checks++;
    assert (lock_tmo === exp_tmo) else begin
      errors++;
      $error("FAIL %s lock_tmo: observed %b expected %b", tag, lock_tmo, exp_tmo);
    end
  endtask

  initial begin
    resetb   = 1'b0;
    porb_l   = 1'b0;
    pll_lock = 1'b1;
    soft_rst = 1'b0;
    tick(3);
    chk("reset", 4'b0000, 1'b0);
    resetb = 1'b1;
    tick(3);
    chk("off_no_porb", 4'b0000, 1'b0);

    // Normal power-up with lock held; porb_l sampled at edge k.
    porb_l = 1'b1;
    tick(2);
    chk("pu_k1", 4'b0000, 1'b0);
    tick(1);
    chk("pu_k2_pll", 4'b1000, 1'b0);
    tick(16);
    chk("pu_k18", 4'b1000, 1'b0);
    tick(1);
    chk("pu_k19_core", 4'b1100, 1'b0);
    tick(7);
    chk("pu_k26", 4'b1100, 1'b0);
    tick(1);
    chk("pu_k27_run", 4'b1111, 1'b0);

    // Soft reset from run.
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("soft_m", 4'b1000, 1'b0);
    tick(15);
    chk("soft_m15", 4'b1000, 1'b0);
    tick(1);
    chk("soft_m16", 4'b1100, 1'b0);
    tick(7);
    chk("soft_m23", 4'b1100, 1'b0);
    tick(1);
    chk("soft_m24", 4'b1111, 1'b0);

    // Lock loss in run without timeout restarts the core.
    pll_lock = 1'b0;
    tick(2);
    chk("lockdrop_j1", 4'b1111, 1'b0);
    tick(1);
    chk("lockdrop_j2", 4'b1000, 1'b0);
    tick(16);
    chk("lockdrop_user", 4'b1100, 1'b0);
    tick(8);
    chk("lockdrop_run", 4'b1111, 1'b0);
    pll_lock = 1'b1;
    tick(4);
    chk("lockrise_run", 4'b1111, 1'b0);

    // Supply loss forces off.
    porb_l = 1'b0;
    tick(2);
    chk("porb_drop_j1", 4'b1111, 1'b0);
    tick(1);
    chk("porb_drop_j2", 4'b0000, 1'b0);

    // Lock timeout: PLL entered at k+2, core state at k+1026.
    pll_lock = 1'b0;
    porb_l   = 1'b1;
    tick(3);
    chk("tmo_pll", 4'b1000, 1'b0);
    tick(1023);
    chk("tmo_k1025", 4'b1000, 1'b0);
    tick(1);
    chk("tmo_k1026", 4'b1000, 1'b1);
    tick(15);
    chk("tmo_k1041", 4'b1000, 1'b1);
    tick(1);
    chk("tmo_k1042_core", 4'b1100, 1'b1);
    tick(8);
    chk("tmo_run", 4'b1111, 1'b1);
    pll_lock = 1'b1;
    tick(4);
    pll_lock = 1'b0;
    tick(4);
    chk("tmo_lockdrop_ignored", 4'b1111, 1'b1);

    // Supply loss with simultaneous soft_rst while in user state.
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    tick(16);
    chk("usr_state", 4'b1100, 1'b1);
    porb_l   = 1'b0;
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("usr_drop_j", 4'b1100, 1'b1);
    tick(1);
    chk("usr_drop_j1", 4'b1100, 1'b1);
    tick(1);
    chk("usr_drop_j2_off", 4'b0000, 1'b0);

    // Asynchronous reset mid-core, then full restart.
    pll_lock = 1'b1;
    porb_l   = 1'b1;
    tick(11);
    chk("mid_core", 4'b1000, 1'b0);
    #2;
    resetb = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 1'b0);
    tick(2);
    chk("held_reset", 4'b0000, 1'b0);
    resetb = 1'b1;
    tick(3);
    chk("restart_pll", 4'b1000, 1'b0);
    tick(16);
    chk("restart_k18", 4'b1000, 1'b0);
    tick(1);
    chk("restart_core", 4'b1100, 1'b0);
    tick(8);
    chk("restart_run", 4'b1111, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
